// File: rtl/if_fetch.sv
// Instruction fetch stage: one registered output slot plus a one-entry skid buffer, redirect draining.
// Optional build macro IF_ALIGN_CHK_EN adds if_misalign and traps misaligned redirect targets.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
`ifdef IF_ALIGN_CHK_EN
  ,
  output logic        if_misalign
`endif
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT_SLOT, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] drain_addr, drain_addr_nx;
  logic [31:0] skid_pc, skid_pc_nx;
  logic [31:0] skid_inst, skid_inst_nx;
  logic [31:0] slot_pc_nx, slot_inst_nx;
  logic        slot_vld_nx;
  logic        halt, halt_nx;
  logic        redir, tgt_bad, consume, req_c;
  logic [31:0] tgt, addr_c;

  assign redir   = flush | br_flag;
  assign consume = if_valid & ~stall;

  always_comb begin
    tgt = flush ? flush_pc : br_target;
`ifdef IF_ALIGN_CHK_EN
    tgt_bad = redir & (tgt[1:0] != 2'b00);
`else
    tgt[1:0] = 2'b00;
    tgt_bad  = 1'b0;
`endif
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    skid_pc_nx    = skid_pc;
    skid_inst_nx  = skid_inst;
    slot_pc_nx    = if_pc;
    slot_inst_nx  = if_inst;
    slot_vld_nx   = if_valid & stall;
    halt_nx       = halt;
    req_c         = 1'b0;
    addr_c        = pc;

    // A redirect always empties the slot, except a trapped target which parks itself there.
    if (redir) begin
      pc_nx       = tgt;
      halt_nx     = tgt_bad;
      slot_vld_nx = tgt_bad;
      if (tgt_bad) begin
        slot_pc_nx   = tgt;
        slot_inst_nx = '0;
      end
    end

    case (state)
      BOOT: begin
        state_nx = (redir && tgt_bad) ? WAIT_SLOT : REQ;
      end
      REQ: begin
        req_c = 1'b1;
        if (redir) begin
          if (imem_ack) begin
            state_nx = tgt_bad ? WAIT_SLOT : REQ;
          end else begin
            drain_addr_nx = pc;
            state_nx      = DRAIN;
          end
        end else if (imem_ack) begin
          pc_nx = pc + 32'd4;
          if (!if_valid || consume) begin
            slot_pc_nx   = pc;
            slot_inst_nx = imem_rdata;
            slot_vld_nx  = 1'b1;
          end else begin
            skid_pc_nx   = pc;
            skid_inst_nx = imem_rdata;
            state_nx     = WAIT_SLOT;
          end
        end
      end
      WAIT_SLOT: begin
        if (redir) begin
          state_nx = tgt_bad ? WAIT_SLOT : REQ;
        end else if (consume && !halt) begin
          slot_pc_nx   = skid_pc;
          slot_inst_nx = skid_inst;
          slot_vld_nx  = 1'b1;
          state_nx     = REQ;
        end
      end
      DRAIN: begin
        // Keep the abandoned request on the bus until memory answers, then throw the data away.
        req_c  = 1'b1;
        addr_c = drain_addr;
        if (imem_ack) state_nx = halt_nx ? WAIT_SLOT : REQ;
      end
      default: state_nx = BOOT;
    endcase
  end

  assign imem_req  = req_c & ~rst;
  assign imem_addr = imem_req ? addr_c : '0;

`ifdef IF_ALIGN_CHK_EN
  assign if_misalign = if_valid & halt;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      halt     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      pc       <= pc_nx;
      halt     <= halt_nx;
      if_valid <= slot_vld_nx;
      if_pc    <= slot_pc_nx;
      if_inst  <= slot_inst_nx;
    end
    drain_addr <= drain_addr_nx;
    skid_pc    <= skid_pc_nx;
    skid_inst  <= skid_inst_nx;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, wait-state and misaligned-target sequences,
// then random traffic scored against a program-order fetch model.
module tb_if_fetch;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        stall      = 1'b0;
  logic        br_flag    = 1'b0;
  logic [31:0] br_target  = '0;
  logic        flush      = 1'b0;
  logic [31:0] flush_pc   = '0;
  logic        imem_ack   = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef IF_ALIGN_CHK_EN
  logic        if_misalign;
  localparam logic [31:0] TMASK = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] TMASK = 32'hFFFF_FFFF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_flag    (br_flag),
    .br_target  (br_target),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
`ifdef IF_ALIGN_CHK_EN
    ,
    .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] ft;
    logic        ack;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    int          chk;    // 0: bus only, 1: bus + if_valid, 2: bus + whole slot
    logic        evld;
    logic [31:0] epc, einst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] bt,
                     input logic f, input logic [31:0] ft, input logic a, input logic [31:0] rd,
                     input logic ereq, input logic [31:0] eaddr, input int chk,
                     input logic evld, input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = r;  v.stall = s; v.br = b; v.bt = bt; v.fl = f; v.ft = ft; v.ack = a; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.chk = chk; v.evld = evld; v.epc = epc; v.einst = einst;
    tbl.push_back(v);
  endtask

  logic [31:0] wa;
  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic        prev_pending;
  logic        redir_last;
  int          wl;
  int          n_consumed;

  initial begin
    // rst stall br bt fl ft ack rdata | req addr | chk vld pc inst
    add(1,0,0,0,     0,0,     0,0,            0,0,      2,0,0,     0);
    add(1,0,0,0,     0,0,     0,0,            0,0,      2,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            0,0,      2,0,0,     0);
    add(0,0,0,0,     0,0,     1,'h1000_0000,  1,'h0,    1,0,0,     0);
    add(0,0,0,0,     0,0,     1,'h1000_0004,  1,'h4,    2,1,'h0,   'h1000_0000);
    add(0,0,0,0,     0,0,     1,'h1000_0008,  1,'h8,    2,1,'h4,   'h1000_0004);
    add(0,0,0,0,     0,0,     1,'h1000_000C,  1,'hC,    2,1,'h8,   'h1000_0008);
    add(0,0,0,0,     0,0,     1,'h1000_0010,  1,'h10,   2,1,'hC,   'h1000_000C);
    add(0,1,0,0,     0,0,     1,'h1000_0014,  1,'h14,   2,1,'h10,  'h1000_0010);
    add(0,1,0,0,     0,0,     0,0,            0,0,      2,1,'h10,  'h1000_0010);
    add(0,1,0,0,     0,0,     0,0,            0,0,      2,1,'h10,  'h1000_0010);
    add(0,1,0,0,     0,0,     0,0,            0,0,      2,1,'h10,  'h1000_0010);
    add(0,0,0,0,     0,0,     0,0,            0,0,      2,1,'h10,  'h1000_0010);
    add(0,0,0,0,     0,0,     0,0,            1,'h18,   2,1,'h14,  'h1000_0014);
    add(0,0,0,0,     0,0,     1,'h1000_0018,  1,'h18,   1,0,0,     0);
    add(0,0,0,0,     0,0,     1,'h1000_001C,  1,'h1C,   2,1,'h18,  'h1000_0018);
    add(0,0,0,0,     0,0,     0,0,            1,'h20,   2,1,'h1C,  'h1000_001C);
    add(0,0,1,'h100, 0,0,     0,0,            1,'h20,   1,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            1,'h20,   1,0,0,     0);
    add(0,0,0,0,     0,0,     1,'hDEAD_0020,  1,'h20,   1,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            1,'h100,  1,0,0,     0);
    add(0,0,1,'h300, 1,'h200, 0,0,            1,'h100,  1,0,0,     0);
    add(0,0,0,0,     0,0,     1,'hDEAD_0100,  1,'h100,  1,0,0,     0);
    add(0,0,0,0,     0,0,     1,'h2000_0200,  1,'h200,  1,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            1,'h204,  2,1,'h200, 'h2000_0200);
    add(0,0,1,'h400, 0,0,     1,'hDEAD_0204,  1,'h204,  1,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            1,'h400,  1,0,0,     0);
    add(1,0,0,0,     0,0,     1,'hDEAD_0400,  0,0,      1,0,0,     0);
    add(0,0,0,0,     0,0,     1,'hDEAD_0000,  0,0,      2,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            1,'h0,    2,0,0,     0);
    add(0,0,0,0,     0,0,     1,'h1000_0000,  1,'h0,    1,0,0,     0);
    add(0,0,0,0,     0,0,     0,0,            1,'h4,    2,1,'h0,   'h1000_0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall; br_flag = tbl[i].br; br_target = tbl[i].bt;
      flush = tbl[i].fl; flush_pc = tbl[i].ft; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rd;
      #1;
      check($sformatf("vec%0d_bus", i), {31'b0, imem_req, imem_addr}, {31'b0, tbl[i].ereq, tbl[i].eaddr});
      if (tbl[i].chk == 1) begin
        check($sformatf("vec%0d_vld", i), {63'b0, if_valid}, {63'b0, tbl[i].evld});
      end else if (tbl[i].chk == 2) begin
        check($sformatf("vec%0d_slot", i), {31'b0, if_valid, if_pc}, {31'b0, tbl[i].evld, tbl[i].epc});
        check($sformatf("vec%0d_inst", i), {32'b0, if_inst}, {32'b0, tbl[i].einst});
      end
    end

    // Two wait states per fetch: request held three cycles, slot valid one cycle in three.
    br_flag = 1'b0; flush = 1'b0; stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        wa = 32'(4 + 4 * k);
        imem_ack   = (j == 2);
        imem_rdata = 32'h3000_0000 | wa;
        #1;
        check("ws_bus", {31'b0, imem_req, imem_addr}, {31'b0, 1'b1, wa});
        check("ws_vld", {63'b0, if_valid}, {63'b0, (j == 0 && k > 0)});
        if (j == 0 && k > 0) check("ws_pc", {32'b0, if_pc}, {32'b0, wa - 32'd4});
      end
    end
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check("ws_last_slot", {31'b0, if_valid, if_pc}, {31'b0, 1'b1, 32'hC});
    check("ws_last_inst", {32'b0, if_inst}, {32'b0, 32'h3000_000C});

    // Redirect to a target with nonzero low bits, coinciding with an ack.
    @(negedge clk);
    br_flag = 1'b1; br_target = 32'h102; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0010;
    #1;
    check("mis_bus", {31'b0, imem_req, imem_addr}, {31'b0, 1'b1, 32'h10});
    @(negedge clk);
    br_flag = 1'b0; imem_ack = 1'b0;
    #1;
`ifdef IF_ALIGN_CHK_EN
    check("mis_req", {63'b0, imem_req}, 64'b0);
    check("mis_slot", {31'b0, if_valid, if_pc}, {31'b0, 1'b1, 32'h102});
    check("mis_inst", {32'b0, if_inst}, 64'b0);
    check("mis_flag", {63'b0, if_misalign}, {63'b0, 1'b1});
    @(negedge clk);
    #1;
    check("mis_halt", {31'b0, imem_req, imem_addr}, 64'b0);
`else
    check("align_bus", {31'b0, imem_req, imem_addr}, {31'b0, 1'b1, 32'h100});
    check("align_vld", {63'b0, if_valid}, 64'b0);
`endif

    // Random traffic: every consumed instruction must follow program order from the last redirect.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; br_flag = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    exp_pc = 32'h0; prev_pending = 1'b0; prev_addr = '0; redir_last = 1'b0; wl = 0; n_consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      stall     = ($urandom_range(0, 9) < 3);
      br_flag   = ($urandom_range(0, 99) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      br_target = $urandom_range(0, 32'h3FFF) & TMASK;
      flush_pc  = $urandom_range(0, 32'h3FFF) & TMASK;
      imem_ack  = 1'b0;
      #1;
      if (prev_pending) check("rnd_hold", {31'b0, imem_req, imem_addr}, {31'b0, 1'b1, prev_addr});
      if (redir_last) check("rnd_redir_vld", {63'b0, if_valid}, 64'b0);
      if (imem_req) begin
        if (!prev_pending) wl = $urandom_range(0, 2);
        imem_ack = (wl == 0);
        if (wl != 0) wl--;
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
      if (if_valid && !stall) begin
        check("rnd_fetch", {if_pc, if_inst}, {exp_pc, mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (flush)        exp_pc = flush_pc & 32'hFFFF_FFFC;
      else if (br_flag) exp_pc = br_target & 32'hFFFF_FFFC;
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      redir_last   = flush || br_flag;
    end
    check("rnd_progress", {63'b0, (n_consumed > 300)}, {63'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high (asserted level `Rsten).
REQ-004 stall  input  1  downstream (IF/ID register) cannot accept an instruction this cycle.
REQ-005 br_flag  input  1  branch redirect request, valid for one cycle.
REQ-006 br_target  input  32  branch target address, sampled when br_flag=1.
REQ-007 flush  input  1  exception/pipeline flush redirect, one cycle; priority over br_flag.
REQ-008 flush_pc  input  32  flush target address, sampled when flush=1.
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_addr  output  32  word-aligned read address.
REQ-011 imem_ack  input  1  read data valid; SHALL be accepted in the same cycle as imem_req (zero wait) or later.
REQ-012 imem_rdata  input  32  read data, valid when imem_ack=1.
REQ-013 if_pc  output  32  PC of the presented instruction (feeds IF/ID if_pc).
REQ-014 if_inst  output  32  presented instruction (feeds IF/ID if_inst).
REQ-015 if_valid  output  1  if_pc/if_inst hold an unconsumed instruction.

Function
REQ-016 Output slot (if_pc, if_inst, if_valid) SHALL be registered; consumed on any rising edge with if_valid=1 and stall=0.
REQ-017 FSM states SHALL be BOOT, REQ, WAIT_SLOT, DRAIN.
REQ-018 BOOT: req=0; next state REQ.
REQ-019 REQ: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-020 REQ with imem_ack and no redirect: load slot (if_pc=pc, if_inst=imem_rdata, if_valid=1); pc<=pc+4 (mod 2^32 wrap); next state REQ if the slot is consumed this edge or was empty, else WAIT_SLOT.
REQ-021 Throughput SHALL be one instruction per cycle with zero-wait memory and stall=0; data appears on if_inst one cycle after ack.
REQ-022 WAIT_SLOT: imem_req=0; move to REQ on the edge where the slot is consumed.
REQ-023 Redirect (flush, else br_flag) SHALL clear if_valid on the same edge and set pc to the target.
REQ-024 Redirect in REQ without ack: go to DRAIN holding the outstanding request; the returned data SHALL be discarded, then REQ at the new pc.
REQ-025 Redirect in the same cycle as imem_ack: data SHALL be discarded, pc<=target, next state REQ.
REQ-026 Redirect in DRAIN: latest target SHALL overwrite the pending target.
REQ-027 Redirect in WAIT_SLOT or BOOT: pc<=target; next state REQ.
REQ-028 Slot contents SHALL stay unchanged while if_valid=1 and stall=1.

Reset
REQ-029 While rst=1: state BOOT, pc=RESET_PC, imem_req=0, imem_addr=`ZWord, if_pc=`ZWord, if_inst=`ZWord, if_valid=0; redirect inputs ignored.
REQ-030 Reset mid-request SHALL abandon the request; a late imem_ack after reset SHALL be ignored until REQ is re-entered.

Configuration
REQ-031 Macro IF_ALIGN_CHK_EN defined: output if_misalign (1 bit, reset 0) exists; a redirect target with [1:0]!=0 SHALL issue no memory request and SHALL load the slot with if_pc=target, if_inst=`ZWord, if_valid=1, if_misalign=1, then wait in WAIT_SLOT for the next redirect.
REQ-032 IF_ALIGN_CHK_EN undefined: no if_misalign port; target bits [1:0] SHALL be forced to 00.

Verification
REQ-033 Reset release, zero-wait memory, stall=0 -> imem_addr 0,4,8 on consecutive cycles; if_pc 0,4,8 one cycle later, if_valid=1 continuously.
REQ-034 Two-wait-state memory -> imem_req/imem_addr stable for 3 cycles per fetch; if_valid pulses every third cycle.
REQ-035 stall=1 for 4 cycles with slot full at pc 0x10 -> if_pc=0x10 and if_inst held, imem_req=0 after the pending ack; fetch of 0x14 resumes after stall drops.
REQ-036 br_flag=1, br_target=0x100 while a request at 0x20 is outstanding -> 0x20 data dropped (if_valid stays 0), next imem_addr=0x100; flush=1 with flush_pc=0x200 in the same cycle -> 0x200 wins.
REQ-037 rst=1 during an outstanding request, ack arriving in the reset cycle -> all outputs zero, first post-reset imem_addr=RESET_PC.
REQ-038 IF_ALIGN_CHK_EN, br_target=0x102 -> no imem_req; if_pc=0x102, if_inst=0, if_misalign=1.
